// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder.
package spi_pkg;
  localparam int         DATA_W_DEF     = 8;
  localparam logic [7:0] DUMMY_BYTE_DEF = 8'hFF;
  localparam bit         CPOL           = 1'b0;
  localparam bit         CPHA           = 1'b0;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulse outputs.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   dly_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= {SYNC_STAGES{RESET_VAL}};
      dly_reg  <= RESET_VAL;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      dly_reg  <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~dly_reg;
  assign fall = ~sync_reg[SYNC_STAGES-1] & dly_reg;
endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder: oversampled sclk/cs_n/mosi, one-entry TX holding buffer,
// back-to-back bytes within one chip-select frame.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] DUMMY_BYTE  = DATA_W'(DUMMY_BYTE_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);
  localparam int CNT_W = $clog2(DATA_W);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .din(cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  // mosi needs the same latency as sclk so the sampled bit lines up with sclk_rise.
  always_ff @(posedge clk) begin
    if (reset) mosi_sync_reg <= '0;
    else       mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  state_t              state_reg;
  logic [DATA_W-1:0]   buf_reg;
  logic                buf_full_reg;
  logic [DATA_W-2:0]   tx_shift_reg;
  logic [DATA_W-2:0]   rx_shift_reg;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic                reload_reg;
  logic                miso_reg, miso_oe_reg, rx_valid_reg, tx_underrun_reg, frame_abort_reg;
  logic [DATA_W-1:0]   data_out_reg;

  logic              byte_start;
  logic              load;
  logic [DATA_W-1:0] next_byte;
  logic              next_underrun;

  assign tx_ready = ~buf_full_reg;
  assign load     = tx_valid & ~buf_full_reg;

  // A byte arriving in the same cycle as byte start bypasses the empty buffer.
  assign next_byte     = buf_full_reg ? buf_reg : (tx_valid ? tx_data : DUMMY_BYTE);
  assign next_underrun = ~buf_full_reg & ~tx_valid;

  always_comb begin
    byte_start = 1'b0;
    if (state_reg == IDLE) byte_start = en & cs_fall;
    else                   byte_start = en & ~cs_rise & sclk_fall & reload_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      buf_reg         <= '0;
      buf_full_reg    <= 1'b0;
      tx_shift_reg    <= '0;
      rx_shift_reg    <= '0;
      bit_cnt_reg     <= '0;
      reload_reg      <= 1'b0;
      miso_reg        <= 1'b0;
      miso_oe_reg     <= 1'b0;
      data_out_reg    <= '0;
      rx_valid_reg    <= 1'b0;
      tx_underrun_reg <= 1'b0;
      frame_abort_reg <= 1'b0;
    end else begin
      rx_valid_reg    <= 1'b0;
      tx_underrun_reg <= 1'b0;
      frame_abort_reg <= 1'b0;

      if (byte_start) begin
        buf_full_reg <= 1'b0;
      end else if (load) begin
        buf_reg      <= tx_data;
        buf_full_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          miso_oe_reg <= 1'b0;
          if (byte_start) begin
            tx_shift_reg    <= next_byte[DATA_W-2:0];
            miso_reg        <= next_byte[DATA_W-1];
            tx_underrun_reg <= next_underrun;
            miso_oe_reg     <= 1'b1;
            bit_cnt_reg     <= '0;
            rx_shift_reg    <= '0;
            reload_reg      <= 1'b0;
            state_reg       <= ACTIVE;
          end
        end
        ACTIVE: begin
          // Deselect (or disable) outranks any sclk edge seen in the same cycle.
          if (!en || cs_rise) begin
            frame_abort_reg <= (bit_cnt_reg != '0);
            miso_oe_reg     <= 1'b0;
            reload_reg      <= 1'b0;
            state_reg       <= IDLE;
          end else begin
            if (sclk_rise) begin
              rx_shift_reg <= {rx_shift_reg[DATA_W-3:0], mosi_s};
              if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
                data_out_reg <= {rx_shift_reg, mosi_s};
                rx_valid_reg <= 1'b1;
                bit_cnt_reg  <= '0;
                reload_reg   <= 1'b1;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
            if (sclk_fall) begin
              if (reload_reg) begin
                tx_shift_reg    <= next_byte[DATA_W-2:0];
                miso_reg        <= next_byte[DATA_W-1];
                tx_underrun_reg <= next_underrun;
                reload_reg      <= 1'b0;
              end else begin
                miso_reg     <= tx_shift_reg[DATA_W-2];
                tx_shift_reg <= {tx_shift_reg[DATA_W-3:0], 1'b0};
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign miso        = miso_reg;
  assign miso_oe     = miso_oe_reg;
  assign data_out    = data_out_reg;
  assign rx_valid    = rx_valid_reg;
  assign tx_underrun = tx_underrun_reg;
  assign frame_abort = frame_abort_reg;
endmodule
